// File: rtl/x_dcm_drp_master.sv
// DRP initiator for the DCM_ADV slave: turns single host requests into DRP
// read, write or masked read-modify-write accesses, one at a time, with a DRDY timeout.
module x_dcm_drp_master #(
  parameter int TIMEOUT = 64
) (
  input  logic        dclk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        req_we,
  input  logic [6:0]  req_addr,
  input  logic [15:0] req_data,
  input  logic [15:0] req_mask,
  output logic        busy,
  output logic        ack,
  output logic        err,
  output logic [15:0] rdata,
  output logic [6:0]  daddr,
  output logic [15:0] di,
  output logic        dwe,
  output logic        den,
  input  logic [15:0] dout,
  input  logic        drdy
);

  localparam logic [15:0] TMO_CNT = 16'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    WR_ISSUE = 3'd3,
    WR_WAIT  = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t      state_reg;
  logic        busy_reg;
  logic        ack_reg;
  logic        err_reg;
  logic [15:0] rdata_reg;
  logic [6:0]  daddr_reg;
  logic [15:0] di_reg;
  logic        dwe_reg;
  logic        den_reg;
  logic [15:0] cnt_reg;
  logic        rmw_reg;
  logic [15:0] data_reg;
  logic [15:0] mask_reg;
  logic [15:0] merged;

  // Write-back word for RMW: masked bits from the host, the rest from the read.
  for (genvar gi = 0; gi < 16; gi++) begin : g_merge
    assign merged[gi] = mask_reg[gi] ? data_reg[gi] : dout[gi];
  end

  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
      rdata_reg <= 16'h0000;
      daddr_reg <= 7'h00;
      di_reg    <= 16'h0000;
      dwe_reg   <= 1'b0;
      den_reg   <= 1'b0;
      cnt_reg   <= 16'h0000;
      rmw_reg   <= 1'b0;
      data_reg  <= 16'h0000;
      mask_reg  <= 16'h0000;
    end else begin
      case (state_reg)
        IDLE: begin
          ack_reg <= 1'b0;
          err_reg <= 1'b0;
          if (req) begin
            busy_reg <= 1'b1;
            data_reg <= req_data;
            mask_reg <= req_mask;
            rmw_reg  <= req_we;
            cnt_reg  <= 16'h0000;
            if (!req_we || (req_mask != 16'hFFFF && req_mask != 16'h0000)) begin
              state_reg <= RD_ISSUE;
              den_reg   <= 1'b1;
              dwe_reg   <= 1'b0;
              daddr_reg <= req_addr;
            end else if (req_mask == 16'hFFFF) begin
              state_reg <= WR_ISSUE;
              den_reg   <= 1'b1;
              dwe_reg   <= 1'b1;
              daddr_reg <= req_addr;
              di_reg    <= req_data;
            end else begin
              // Nothing to write: complete without touching the DRP.
              state_reg <= DONE;
              ack_reg   <= 1'b1;
            end
          end
        end

        RD_ISSUE: begin
          den_reg   <= 1'b0;
          cnt_reg   <= cnt_reg + 16'd1;
          state_reg <= RD_WAIT;
        end

        RD_WAIT: begin
          if (drdy) begin
            rdata_reg <= dout;
            cnt_reg   <= 16'h0000;
            if (rmw_reg) begin
              state_reg <= WR_ISSUE;
              den_reg   <= 1'b1;
              dwe_reg   <= 1'b1;
              di_reg    <= merged;
            end else begin
              state_reg <= DONE;
              ack_reg   <= 1'b1;
              err_reg   <= 1'b0;
            end
          end else if (cnt_reg == TMO_CNT) begin
            // Timed-out read phase: report zero data and skip any write-back.
            state_reg <= DONE;
            ack_reg   <= 1'b1;
            err_reg   <= 1'b1;
            rdata_reg <= 16'h0000;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end

        WR_ISSUE: begin
          den_reg   <= 1'b0;
          dwe_reg   <= 1'b0;
          cnt_reg   <= cnt_reg + 16'd1;
          state_reg <= WR_WAIT;
        end

        WR_WAIT: begin
          if (drdy) begin
            state_reg <= DONE;
            ack_reg   <= 1'b1;
            err_reg   <= 1'b0;
          end else if (cnt_reg == TMO_CNT) begin
            state_reg <= DONE;
            ack_reg   <= 1'b1;
            err_reg   <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end

        DONE: begin
          ack_reg   <= 1'b0;
          err_reg   <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          ack_reg   <= 1'b0;
          err_reg   <= 1'b0;
          den_reg   <= 1'b0;
          dwe_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_reg;
  assign ack   = ack_reg;
  assign err   = err_reg;
  assign rdata = rdata_reg;
  assign daddr = daddr_reg;
  assign di    = di_reg;
  assign dwe   = dwe_reg;
  assign den   = den_reg;

endmodule
